// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect inputs, fetch handshake and PC outputs of pc_fetch_ctrl.
// master = the PC controller, slave = decode/branch logic plus instruction memory.
interface pc_fetch_if #(
   parameter int XLEN = 32
);
   logic            en;
   logic [1:0]      redirect_sel;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] pc_adder_result;
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign_trap;
   logic [XLEN-1:0] bad_addr;
   modport master (
      input  en, redirect_sel, alu_result, pc_adder_result, req_ready,
      output req_valid, req_addr, pc, pc_plus4, misalign_trap, bad_addr
   );
   modport slave (
      output en, redirect_sel, alu_result, pc_adder_result, req_ready,
      input  req_valid, req_addr, pc, pc_plus4, misalign_trap, bad_addr
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter with valid/ready fetch handshake and a one-entry redirect buffer.
// Define PC_ALIGN_TRAP_EN to trap misaligned ALU/PC_ADDER targets instead of truncating them.
module pc_fetch_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
   input logic        clk,
   input logic        rst,
   pc_fetch_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, WAIT, WAIT_REDIR} state_e;
   localparam logic [1:0] SEL_SEQ   = 2'd0;
   localparam logic [1:0] SEL_ALU   = 2'd1;
   localparam logic [1:0] SEL_TRAP  = 2'd3;
   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pend_q, pend_d;
   logic [XLEN-1:0] pc_plus4, user_tgt, target;
   logic            redir, pc_ld, pend_ld, use_pend;
   assign pc_plus4 = pc_q + XLEN'(4);
   assign redir    = bus.redirect_sel != SEL_SEQ;
   assign user_tgt = bus.redirect_sel == SEL_ALU ? bus.alu_result : bus.pc_adder_result;
`ifdef PC_ALIGN_TRAP_EN
   logic            misaligned, mis_q;
   logic [XLEN-1:0] bad_q;
   assign misaligned = redir && bus.redirect_sel != SEL_TRAP && |user_tgt[1:0];
   assign target = bus.redirect_sel == SEL_SEQ ? pc_plus4 :
                   (bus.redirect_sel == SEL_TRAP || misaligned) ? TRAP_VECTOR : user_tgt;
   // The trap fires only when the bad target actually lands in pc or pend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
         bad_q <= '0;
      end else begin
         mis_q <= misaligned & (pc_ld | pend_ld);
         if (misaligned & (pc_ld | pend_ld)) bad_q <= user_tgt;
      end
   end
   assign bus.misalign_trap = mis_q;
   assign bus.bad_addr      = bad_q;
`else
   assign target = bus.redirect_sel == SEL_SEQ  ? pc_plus4 :
                   bus.redirect_sel == SEL_TRAP ? TRAP_VECTOR : user_tgt & ~XLEN'(3);
   assign bus.misalign_trap = 1'b0;
   assign bus.bad_addr      = '0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end
   // With no request outstanding (RUN, !en) a redirect goes straight into pc.
   always_comb begin
      state_d  = state_q;
      pc_ld    = 1'b0;
      pend_ld  = 1'b0;
      use_pend = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (bus.en) begin
               pc_ld   = bus.req_ready;
               pend_ld = !bus.req_ready && redir;
               state_d = bus.req_ready ? RUN : redir ? WAIT_REDIR : WAIT;
            end else begin
               pc_ld = redir;
            end
         end
         WAIT: begin
            pc_ld   = bus.req_ready;
            pend_ld = !bus.req_ready && redir;
            state_d = bus.req_ready ? RUN : redir ? WAIT_REDIR : WAIT;
         end
         WAIT_REDIR: begin
            pc_ld    = bus.req_ready;
            use_pend = !redir;
            pend_ld  = !bus.req_ready && redir;
            state_d  = bus.req_ready ? RUN : WAIT_REDIR;
         end
         default: state_d = BOOT;
      endcase
   end
   assign pc_d   = !pc_ld ? pc_q : use_pend ? pend_q : target;
   assign pend_d = pend_ld ? target : pend_q;
   always_comb begin
      bus.req_valid = state_q == RUN ? bus.en : state_q != BOOT;
      bus.req_addr  = pc_q;
      bus.pc        = pc_q;
      bus.pc_plus4  = pc_plus4;
   end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of reset, stall, buffered redirects, wrap and alignment handling.
module tb_pc_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   pc_fetch_if #(.XLEN(32)) bus ();
   pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [1:0] s, input logic [31:0] alu,
                        input logic [31:0] padd, input logic rdy);
      bus.en              = e;
      bus.redirect_sel    = s;
      bus.alu_result      = alu;
      bus.pc_adder_result = padd;
      bus.req_ready       = rdy;
   endtask

   // From RUN with en=0 a redirect loads pc directly.
   task automatic go_pc(input logic [31:0] a);
      drive(1'b0, 2'd2, 32'h0, a, 1'b0);
      tick;
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_reset;
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      #12;
      checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL reset_pc got %h exp 00000080", bus.pc); end
      checks++; if (bus.req_addr !== 32'h80) begin errors++; $display("FAIL reset_addr got %h exp 00000080", bus.req_addr); end
      checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.req_valid); end
      checks++; if (bus.pc_plus4 !== 32'h84) begin errors++; $display("FAIL reset_pc4 got %h exp 00000084", bus.pc_plus4); end
      checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b exp 0", bus.misalign_trap); end
      checks++; if (bus.bad_addr !== 32'h0) begin errors++; $display("FAIL reset_bad got %h exp 0", bus.bad_addr); end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      #1;
      checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", bus.req_valid); end
      tick;
      checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", bus.req_valid); end
      checks++; if (bus.req_addr !== 32'h80) begin errors++; $display("FAIL seq0 got %h exp 00000080", bus.req_addr); end
      tick;
      checks++; if (bus.req_addr !== 32'h84) begin errors++; $display("FAIL seq1 got %h exp 00000084", bus.req_addr); end
      tick;
      checks++; if (bus.req_addr !== 32'h88) begin errors++; $display("FAIL seq2 got %h exp 00000088", bus.req_addr); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_hold;
      go_pc(32'h60);
      tick;
      checks++; if (bus.pc !== 32'h60) begin errors++; $display("FAIL idle_hold got %h exp 00000060", bus.pc); end
      checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.req_valid); end
   endtask

   task automatic test_stall;
      go_pc(32'h40);
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tick;
      for (int i = 0; i < 3; i++) begin
         bus.en = (i == 1);
         #1;
         checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b exp 1", i, bus.req_valid); end
         checks++; if (bus.req_addr !== 32'h40) begin errors++; $display("FAIL stall_addr%0d got %h exp 00000040", i, bus.req_addr); end
         tick;
      end
      bus.req_ready = 1'b1;
      tick;
      checks++; if (bus.pc !== 32'h44) begin errors++; $display("FAIL stall_release got %h exp 00000044", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_buffered;
      go_pc(32'h10);
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      tick;
      drive(1'b1, 2'd2, 32'h0, 32'h200, 1'b0);
      tick;
      checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL buf_hold got %h exp 00000010", bus.pc); end
      checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL buf_valid got %b exp 1", bus.req_valid); end
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL buf_apply got %h exp 00000200", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_overwrite;
      go_pc(32'h10);
      drive(1'b1, 2'd2, 32'h0, 32'h200, 1'b0);
      tick;
      drive(1'b0, 2'd1, 32'h500, 32'h0, 1'b0);
      #1;
      checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", bus.req_valid); end
      tick;
      checks++; if (bus.req_addr !== 32'h10) begin errors++; $display("FAIL ovr_addr got %h exp 00000010", bus.req_addr); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h500) begin errors++; $display("FAIL ovr_apply got %h exp 00000500", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_collision;
      go_pc(32'h10);
      drive(1'b1, 2'd2, 32'h0, 32'h200, 1'b0);
      tick;
      drive(1'b1, 2'd1, 32'h300, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h300) begin errors++; $display("FAIL collide got %h exp 00000300", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_wrap;
      go_pc(32'hFFFF_FFFC);
      checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4a got %h exp 00000000", bus.pc_plus4); end
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", bus.pc); end
      checks++; if (bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_pc4b got %h exp 00000004", bus.pc_plus4); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back;
      go_pc(32'h1000);
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h1004) begin errors++; $display("FAIL b2b0 got %h exp 00001004", bus.pc); end
      tick;
      checks++; if (bus.pc !== 32'h1008) begin errors++; $display("FAIL b2b1 got %h exp 00001008", bus.pc); end
      drive(1'b1, 2'd1, 32'h2000, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h2000) begin errors++; $display("FAIL b2b_alu got %h exp 00002000", bus.pc); end
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h2004) begin errors++; $display("FAIL b2b2 got %h exp 00002004", bus.pc); end
      drive(1'b1, 2'd3, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL b2b_trap got %h exp 00000100", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_misalign;
      go_pc(32'h40);
      drive(1'b1, 2'd1, 32'h123, 32'h0, 1'b1);
      tick;
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
`ifdef PC_ALIGN_TRAP_EN
      checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL mis_pc got %h exp 00000100", bus.pc); end
      checks++; if (bus.misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap got %b exp 1", bus.misalign_trap); end
      checks++; if (bus.bad_addr !== 32'h123) begin errors++; $display("FAIL mis_bad got %h exp 00000123", bus.bad_addr); end
      tick;
      checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b exp 0", bus.misalign_trap); end
      checks++; if (bus.bad_addr !== 32'h123) begin errors++; $display("FAIL mis_keep got %h exp 00000123", bus.bad_addr); end
`else
      checks++; if (bus.pc !== 32'h120) begin errors++; $display("FAIL mis_pc got %h exp 00000120", bus.pc); end
      checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_trap got %b exp 0", bus.misalign_trap); end
      checks++; if (bus.bad_addr !== 32'h0) begin errors++; $display("FAIL mis_bad got %h exp 00000000", bus.bad_addr); end
      drive(1'b0, 2'd2, 32'h0, 32'h207, 1'b0);
      tick;
      checks++; if (bus.pc !== 32'h204) begin errors++; $display("FAIL mis_padd got %h exp 00000204", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
`endif
   endtask

   task automatic test_async_reset;
      go_pc(32'h10);
      drive(1'b1, 2'd2, 32'h0, 32'h200, 1'b0);
      tick;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.req_valid); end
      checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL arst_pc got %h exp 00000080", bus.pc); end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
      tick;
      checks++; if (bus.req_addr !== 32'h80) begin errors++; $display("FAIL arst_addr got %h exp 00000080", bus.req_addr); end
      tick;
      checks++; if (bus.pc !== 32'h84) begin errors++; $display("FAIL arst_pend got %h exp 00000084", bus.pc); end
      drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset;
      test_hold;
      test_stall;
      test_buffered;
      test_overwrite;
      test_collision;
      test_wrap;
      test_back_to_back;
      test_misalign;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
